ahb_grant_sequencer: RTL and testbench
======================================

Name: ahb_grant_sequencer

Overview:
- Sits directly downstream of the combinational AHB priority arbiter. Consumes its one-hot grant and winner index and turns them into registered, burst-safe AHB bus ownership (hgrant/hmaster/hmaster_data).
- Re-arbitrates only at legal AHB handover points: end of single transfer, last beat of a fixed burst, IDLE, or forced release of an over-long INCR.
- Guarantees the CPU preemption chosen by the arbiter never breaks an in-flight burst or a locked sequence.

Parameters:
- NUM_MASTERS, 4, number of AHB masters; must equal arbiter NUM_MASTERS.
- MAX_HOLD, 64, maximum cycles an undefined-length INCR owner keeps the bus before forced release; range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- arb_grant  in  NUM_MASTERS  one-hot grant from arbiter (all-zero = no request)
- arb_winner  in  $clog2(NUM_MASTERS)  winner index from arbiter
- m_htrans  in  NUM_MASTERS*2  per-master HTRANS, master i at [i*2+:2]
- m_hburst  in  NUM_MASTERS*3  per-master HBURST, master i at [i*3+:3]
- m_hmastlock  in  NUM_MASTERS  per-master HMASTLOCK
- hready  in  1  bus HREADY
- hgrant  out  NUM_MASTERS  registered one-hot bus grant
- hmaster  out  $clog2(NUM_MASTERS)  address-phase owner
- hmaster_data  out  $clog2(NUM_MASTERS)  data-phase owner
- hmastlock_out  out  1  owner's lock, registered
- force_release  out  1  one-cycle pulse on MAX_HOLD expiry
- seq_state  out  2  current state, for debug

Behaviour:
- Reset (rst_n=0 at posedge): hgrant=0, hmaster=0, hmaster_data=0, hmastlock_out=0, force_release=0, state=IDLE, beat_cnt=0, hold_cnt=0. Reset asserted mid-burst aborts immediately with the same values.
- Owner signals: own_htrans=m_htrans[hmaster], own_hburst, own_lock.
- hmaster_data <= hmaster on every cycle with hready=1; holds otherwise. hmastlock_out <= own_lock when hready=1.
- Handover action (only when hready=1):
  - If |arb_grant: hgrant <= onehot(arb_winner), hmaster <= arb_winner, state <= OWNED.
  - Else: hgrant <= 0, hmaster holds, state <= IDLE.
  - Re-granting the same master is legal. hgrant is derived only from arb_winner, so a multi-hot arb_grant cannot produce a multi-hot hgrant.
- Lock rule: if own_lock=1 at a would-be handover, no handover occurs. Owner keeps the bus and state becomes OWNED. Lock overrides forced release.
- States (encoding IDLE=0, OWNED=1, BURST=2, INCR=3):
  - IDLE: perform handover action every hready cycle.
  - OWNED, on hready, decode own_htrans:
    - NONSEQ+SINGLE → handover point.
    - NONSEQ+fixed burst (INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16 beats) → BURST, beat_cnt <= L-1.
    - NONSEQ+INCR → INCR, hold_cnt <= 0.
    - IDLE → handover point.
    - BUSY or SEQ → stay.
  - BURST, on hready:
    - SEQ with beat_cnt>1 → beat_cnt-1.
    - SEQ with beat_cnt==1 (last beat address accepted) → handover point; new owner's address phase follows next cycle with zero dead cycles.
    - IDLE (early termination) → handover point.
    - NONSEQ → re-decode as in OWNED.
    - BUSY → hold.
  - INCR:
    - hold_cnt increments every clk (saturating).
    - On hready: IDLE → handover point; NONSEQ → re-decode.
    - If hold_cnt==MAX_HOLD-1 and hready and !own_lock → forced handover with force_release=1 for exactly that cycle.
- hready=0: no state, grant or owner change; beat_cnt frozen; hold_cnt still counts.
- Latency: arbiter decision to hgrant = 1 clk at a handover point. hmaster_data lags hmaster by one hready cycle.

Decomposition:
- Shared package ahb_arb_pkg:
  - HTRANS codes: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HBURST codes: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
  - Sequencer state encoding.
  - The existing arbiter priority constants (CPU=3, CIM=2, NET=1, DMA=0).
- One combinational sub-module, ahb_burst_len_decode: hburst → {is_fixed, len[4:0]}.

Test Plan:
1. Reset/idle: rst_n low 3 clks with arb_grant=4'b0100 → hgrant=0, hmaster=0. First clk after release with hready=1 → hgrant=4'b0100, hmaster=2.
2. INCR4 burst not preempted: master 0 (DMA) owns, NONSEQ+INCR4, then 3 SEQ. arb_winner switches to 3 (CPU) after beat 1 → hgrant stays 4'b0001 until the cycle after the 3rd SEQ, then 4'b1000. hmaster_data=0 for the last data phase.
3. Wait states: INCR8 with hready=0 for 2 cycles mid-burst → beat_cnt frozen. Handover occurs only after 7 accepted SEQ beats.
4. Lock: master 1 asserts m_hmastlock across two SINGLE transfers while CPU requests → no handover until the lock drops. CPU then granted on the next handover point.
5. INCR hog, MAX_HOLD=8: master 2 INCR with continuous SEQ → force_release=1 exactly 8 clks after NONSEQ; hgrant → arbiter winner. Repeat with lock high → no force_release.
6. Early termination: INCR16 owner issues IDLE after 5 beats → handover that cycle. arb_grant=0 → hgrant=0, state=IDLE, hmaster unchanged.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbitration types: transfer/burst codes, sequencer states and master priorities.
package ahb_arb_pkg;

    localparam int unsigned HTRANS_W    = 2;
    localparam int unsigned HBURST_W    = 3;
    localparam int unsigned BURST_LEN_W = 5;
    localparam int unsigned SEQ_STATE_W = 2;

    typedef enum logic [HTRANS_W-1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [HBURST_W-1:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_OWNED = 2'd1,
        SEQ_BURST = 2'd2,
        SEQ_INCR  = 2'd3
    } seq_state_e;

    // Master indices as ranked by the upstream priority arbiter.
    typedef enum logic [1:0] {
        PRI_DMA = 2'd0,
        PRI_NET = 2'd1,
        PRI_CIM = 2'd2,
        PRI_CPU = 2'd3
    } master_pri_e;

    typedef struct packed {
        logic                   is_fixed;
        logic [BURST_LEN_W-1:0] len;
    } burst_info_t;

endpackage

// File: rtl/ahb_grant_sequencer_if.sv
// Signal bundle between the priority arbiter, the AHB masters and the grant sequencer.
interface ahb_grant_sequencer_if
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
);
    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0]          arb_grant;
    logic [IDX_W-1:0]                arb_winner;
    logic [NUM_MASTERS*HTRANS_W-1:0] m_htrans;
    logic [NUM_MASTERS*HBURST_W-1:0] m_hburst;
    logic [NUM_MASTERS-1:0]          m_hmastlock;
    logic                            hready;
    logic [NUM_MASTERS-1:0]          hgrant;
    logic [IDX_W-1:0]                hmaster;
    logic [IDX_W-1:0]                hmaster_data;
    logic                            hmastlock_out;
    logic                            force_release;
    logic [SEQ_STATE_W-1:0]          seq_state;

    modport master (
        output arb_grant, arb_winner, m_htrans, m_hburst, m_hmastlock, hready,
        input  hgrant, hmaster, hmaster_data, hmastlock_out, force_release, seq_state
    );

    modport slave (
        input  arb_grant, arb_winner, m_htrans, m_hburst, m_hmastlock, hready,
        output hgrant, hmaster, hmaster_data, hmastlock_out, force_release, seq_state
    );

endinterface

// File: rtl/ahb_burst_len_decode.sv
// Maps HBURST to fixed-length flag and beat count (0 length for SINGLE/INCR).
module ahb_burst_len_decode
    import ahb_arb_pkg::*;
(
    input  logic [HBURST_W-1:0] hburst,
    output burst_info_t         burst_c
);

    always_comb begin
        burst_c = '0;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_c = '{is_fixed: 1'b1, len: BURST_LEN_W'(4)};
            HBURST_WRAP8,  HBURST_INCR8:  burst_c = '{is_fixed: 1'b1, len: BURST_LEN_W'(8)};
            HBURST_WRAP16, HBURST_INCR16: burst_c = '{is_fixed: 1'b1, len: BURST_LEN_W'(16)};
            default:                      burst_c = '0;
        endcase
    end

endmodule

// File: rtl/ahb_grant_sequencer.sv
// Turns the arbiter's per-cycle decision into registered, burst- and lock-safe AHB bus ownership,
// changing owner only at legal handover points.
module ahb_grant_sequencer
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_HOLD    = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    ahb_grant_sequencer_if.slave bus
);

    localparam int unsigned       IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned       HOLD_W    = 16;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    seq_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [IDX_W-1:0]       hmaster_q, hmaster_d;
    logic [IDX_W-1:0]       hmaster_data_q, hmaster_data_d;
    logic                   hmastlock_q, hmastlock_d;
    logic                   force_q, force_d;
    logic [BURST_LEN_W-1:0] beat_q, beat_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    logic [HTRANS_W-1:0]    htrans_arr [NUM_MASTERS];
    logic [HBURST_W-1:0]    hburst_arr [NUM_MASTERS];
    logic [HTRANS_W-1:0]    own_htrans_c;
    logic [HBURST_W-1:0]    own_hburst_c;
    logic                   own_lock_c;
    burst_info_t            own_burst_c;
    logic                   handover_c;
    logic                   redecode_c;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_split
        assign htrans_arr[i] = bus.m_htrans[i*HTRANS_W +: HTRANS_W];
        assign hburst_arr[i] = bus.m_hburst[i*HBURST_W +: HBURST_W];
    end

    // Current address-phase owner's transfer controls.
    assign own_htrans_c = htrans_arr[hmaster_q];
    assign own_hburst_c = hburst_arr[hmaster_q];
    assign own_lock_c   = bus.m_hmastlock[hmaster_q];

    ahb_burst_len_decode u_len_decode (
        .hburst  (own_hburst_c),
        .burst_c (own_burst_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= SEQ_IDLE;
            hgrant_q       <= '0;
            hmaster_q      <= '0;
            hmaster_data_q <= '0;
            hmastlock_q    <= 1'b0;
            force_q        <= 1'b0;
            beat_q         <= '0;
            hold_q         <= '0;
        end else begin
            state_q        <= state_d;
            hgrant_q       <= hgrant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
            force_q        <= force_d;
            beat_q         <= beat_d;
            hold_q         <= hold_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hgrant_d       = hgrant_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        hmastlock_d    = hmastlock_q;
        force_d        = 1'b0;
        beat_d         = beat_q;
        hold_d         = '0;
        handover_c     = 1'b0;
        redecode_c     = 1'b0;

        // The INCR age keeps running through wait states.
        if (state_q == SEQ_INCR) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
        end

        if (bus.hready) begin
            hmaster_data_d = hmaster_q;
            hmastlock_d    = own_lock_c;

            case (state_q)
                SEQ_IDLE: handover_c = 1'b1;
                SEQ_OWNED: begin
                    if (own_htrans_c == HTRANS_NONSEQ)    redecode_c = 1'b1;
                    else if (own_htrans_c == HTRANS_IDLE) handover_c = 1'b1;
                end
                SEQ_BURST: begin
                    case (own_htrans_c)
                        HTRANS_SEQ: begin
                            if (beat_q > BURST_LEN_W'(1)) beat_d = beat_q - BURST_LEN_W'(1);
                            else                          handover_c = 1'b1;
                        end
                        HTRANS_IDLE:   handover_c = 1'b1;
                        HTRANS_NONSEQ: redecode_c = 1'b1;
                        default:       ;
                    endcase
                end
                SEQ_INCR: begin
                    if (hold_q == HOLD_LAST && !own_lock_c) begin
                        handover_c = 1'b1;
                        force_d    = 1'b1;
                    end else if (own_htrans_c == HTRANS_NONSEQ) begin
                        redecode_c = 1'b1;
                    end else if (own_htrans_c == HTRANS_IDLE) begin
                        handover_c = 1'b1;
                    end
                end
                default: ;
            endcase

            // A fresh NONSEQ picks the tracking mode from its burst type.
            if (redecode_c) begin
                if (own_burst_c.is_fixed) begin
                    state_d = SEQ_BURST;
                    beat_d  = own_burst_c.len - BURST_LEN_W'(1);
                end else if (own_hburst_c == HBURST_INCR) begin
                    state_d = SEQ_INCR;
                    hold_d  = '0;
                end else begin
                    handover_c = 1'b1;
                end
            end

            // A locked owner keeps the bus even at a handover point.
            if (handover_c) begin
                if (own_lock_c) begin
                    state_d  = SEQ_OWNED;
                    hgrant_d = NUM_MASTERS'(1) << hmaster_q;
                end else if (|bus.arb_grant) begin
                    state_d   = SEQ_OWNED;
                    hgrant_d  = NUM_MASTERS'(1) << bus.arb_winner;
                    hmaster_d = bus.arb_winner;
                end else begin
                    state_d  = SEQ_IDLE;
                    hgrant_d = '0;
                end
            end
        end
    end

    assign bus.hgrant        = hgrant_q;
    assign bus.hmaster       = hmaster_q;
    assign bus.hmaster_data  = hmaster_data_q;
    assign bus.hmastlock_out = hmastlock_q;
    assign bus.force_release = force_q;
    assign bus.seq_state     = state_q;

endmodule

// File: tb/tb_ahb_grant_sequencer.sv
// Bench for ahb_grant_sequencer: directed vector table, multi-cycle corner sequences and
// randomized traffic against an ownership model.
module tb_ahb_grant_sequencer;

    localparam int unsigned NM       = 4;
    localparam int unsigned MAX_HOLD = 8;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [2:0] B_INCR16 = 3'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    ahb_grant_sequencer_if #(.NUM_MASTERS(NM)) bus ();

    ahb_grant_sequencer #(
        .NUM_MASTERS (NM),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Ownership model: who holds the bus, how many burst beats remain, and how long an
    // open-ended INCR has been running.
    int         mdl_owner = 0;
    bit         mdl_free  = 1'b1;
    int         mdl_left  = 0;
    bit         mdl_open  = 1'b0;
    int         mdl_age   = 0;
    logic [3:0] mdl_hgrant = '0;
    logic [1:0] mdl_hmdata = '0;
    logic       mdl_lock   = 1'b0;
    logic       mdl_force  = 1'b0;

    always @(posedge clk) begin : p_model
        int own;
        int tr;
        int hb;
        int old_age;
        bit lk;
        bit rel;
        if (!rst_n) begin
            mdl_owner = 0; mdl_free = 1'b1; mdl_left = 0; mdl_open = 1'b0; mdl_age = 0;
            mdl_hgrant = '0; mdl_hmdata = '0; mdl_lock = 1'b0; mdl_force = 1'b0;
        end else begin
            own     = mdl_owner;
            tr      = int'(bus.m_htrans[own*2 +: 2]);
            hb      = int'(bus.m_hburst[own*3 +: 3]);
            lk      = bus.m_hmastlock[own];
            old_age = mdl_age;
            rel     = 1'b0;
            mdl_force = 1'b0;
            if (mdl_open && mdl_age < 65535) mdl_age = mdl_age + 1;
            if (bus.hready) begin
                mdl_hmdata = 2'(own);
                mdl_lock   = lk;
                if (mdl_free) rel = 1'b1;
                else if (mdl_open && old_age == int'(MAX_HOLD) - 1 && !lk) begin
                    rel = 1'b1;
                    mdl_force = 1'b1;
                end else if (tr == 2) begin
                    if (hb >= 2) begin
                        mdl_left = (4 << ((hb - 2) / 2)) - 1;
                        mdl_open = 1'b0;
                    end else if (hb == 1) begin
                        mdl_open = 1'b1; mdl_age = 0; mdl_left = 0;
                    end else rel = 1'b1;
                end else if (tr == 0) rel = 1'b1;
                else if (tr == 3 && mdl_left > 0) begin
                    if (mdl_left > 1) mdl_left = mdl_left - 1;
                    else rel = 1'b1;
                end
                if (rel) begin
                    mdl_left = 0;
                    mdl_open = 1'b0;
                    if (lk) begin
                        mdl_free   = 1'b0;
                        mdl_hgrant = 4'(1 << own);
                    end else if (bus.arb_grant != '0) begin
                        mdl_owner  = int'(bus.arb_winner);
                        mdl_free   = 1'b0;
                        mdl_hgrant = 4'(1 << mdl_owner);
                    end else begin
                        mdl_free   = 1'b1;
                        mdl_hgrant = '0;
                    end
                end
            end
        end
    end

    function automatic int mdl_state();
        if (mdl_free)     return 0;
        if (mdl_left > 0) return 2;
        if (mdl_open)     return 3;
        return 1;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endfunction

    task automatic drive(input logic [3:0] g, input logic [1:0] w, input logic [1:0] tr,
                         input logic [2:0] hb, input logic [3:0] lk, input logic rdy);
        bus.arb_grant   = g;
        bus.arb_winner  = w;
        bus.m_htrans    = {4{tr}};
        bus.m_hburst    = {4{hb}};
        bus.m_hmastlock = lk;
        bus.hready      = rdy;
    endtask

    // One clock, then compare every output against the model away from the edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check("mdl_hgrant",       32'(bus.hgrant),        32'(mdl_hgrant));
        check("mdl_hmaster",      32'(bus.hmaster),       32'(mdl_owner));
        check("mdl_hmaster_data", 32'(bus.hmaster_data),  32'(mdl_hmdata));
        check("mdl_state",        32'(bus.seq_state),     32'(mdl_state()));
        check("mdl_hmastlock",    32'(bus.hmastlock_out), 32'(mdl_lock));
        check("mdl_force",        32'(bus.force_release), 32'(mdl_force));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] g;
        logic [1:0] w;
        logic [1:0] tr;
        logic [2:0] hb;
        logic       rdy;
        logic [3:0] e_gnt;
        logic [1:0] e_mst;
        logic [1:0] e_mdata;
        logic [1:0] e_st;
    } vec_t;

    vec_t vt [17];

    initial begin
        logic [7:0]  tr_v;
        logic [11:0] hb_v;
        logic [3:0]  lk_v;
        logic [1:0]  w;

        // Reset/idle grant, INCR4 not preempted by CPU, INCR16 early IDLE with no requester.
        vt[0]  = '{1'b0, 4'b0100, 2'd2, T_IDLE,   B_SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 2'd0};
        vt[1]  = '{1'b0, 4'b0100, 2'd2, T_IDLE,   B_SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 2'd0};
        vt[2]  = '{1'b0, 4'b0100, 2'd2, T_IDLE,   B_SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 2'd0};
        vt[3]  = '{1'b1, 4'b0100, 2'd2, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0, 2'd1};
        vt[4]  = '{1'b1, 4'b0001, 2'd0, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd2, 2'd1};
        vt[5]  = '{1'b1, 4'b0001, 2'd0, T_NONSEQ, B_INCR4,  1'b1, 4'b0001, 2'd0, 2'd0, 2'd2};
        vt[6]  = '{1'b1, 4'b0001, 2'd0, T_SEQ,    B_INCR4,  1'b1, 4'b0001, 2'd0, 2'd0, 2'd2};
        vt[7]  = '{1'b1, 4'b1000, 2'd3, T_SEQ,    B_INCR4,  1'b1, 4'b0001, 2'd0, 2'd0, 2'd2};
        vt[8]  = '{1'b1, 4'b1000, 2'd3, T_SEQ,    B_INCR4,  1'b1, 4'b1000, 2'd3, 2'd0, 2'd1};
        vt[9]  = '{1'b1, 4'b1000, 2'd3, T_NONSEQ, B_INCR16, 1'b1, 4'b1000, 2'd3, 2'd3, 2'd2};
        vt[10] = '{1'b1, 4'b1000, 2'd3, T_SEQ,    B_INCR16, 1'b1, 4'b1000, 2'd3, 2'd3, 2'd2};
        vt[11] = '{1'b1, 4'b1000, 2'd3, T_SEQ,    B_INCR16, 1'b1, 4'b1000, 2'd3, 2'd3, 2'd2};
        vt[12] = '{1'b1, 4'b1000, 2'd3, T_SEQ,    B_INCR16, 1'b1, 4'b1000, 2'd3, 2'd3, 2'd2};
        vt[13] = '{1'b1, 4'b1000, 2'd3, T_SEQ,    B_INCR16, 1'b1, 4'b1000, 2'd3, 2'd3, 2'd2};
        vt[14] = '{1'b1, 4'b0000, 2'd0, T_IDLE,   B_INCR16, 1'b1, 4'b0000, 2'd3, 2'd3, 2'd0};
        vt[15] = '{1'b1, 4'b0010, 2'd1, T_IDLE,   B_SINGLE, 1'b0, 4'b0000, 2'd3, 2'd3, 2'd0};
        vt[16] = '{1'b1, 4'b0010, 2'd1, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd1, 2'd3, 2'd1};

        drive(4'b0, 2'd0, T_IDLE, B_SINGLE, 4'b0, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            rst_n = vt[i].rst;
            drive(vt[i].g, vt[i].w, vt[i].tr, vt[i].hb, 4'b0, vt[i].rdy);
            cyc();
            check($sformatf("vec%0d_hgrant", i),       32'(bus.hgrant),        32'(vt[i].e_gnt));
            check($sformatf("vec%0d_hmaster", i),      32'(bus.hmaster),       32'(vt[i].e_mst));
            check($sformatf("vec%0d_hmaster_data", i), 32'(bus.hmaster_data),  32'(vt[i].e_mdata));
            check($sformatf("vec%0d_state", i),        32'(bus.seq_state),     32'(vt[i].e_st));
            check($sformatf("vec%0d_force", i),        32'(bus.force_release), 32'd0);
        end

        // INCR8 with two wait states: owner 1 keeps the bus until the 7th accepted SEQ.
        drive(4'b0010, 2'd1, T_NONSEQ, B_INCR8, 4'b0, 1'b1);
        cyc();
        check("t3_start_state", 32'(bus.seq_state), 32'd2);
        for (int k = 1; k <= 7; k++) begin
            drive(4'b1000, 2'd3, T_SEQ, B_INCR8, 4'b0, 1'b1);
            cyc();
            check($sformatf("t3_beat%0d_hgrant", k), 32'(bus.hgrant), (k == 7) ? 32'h8 : 32'h2);
            if (k == 3) begin
                for (int s = 0; s < 2; s++) begin
                    drive(4'b1000, 2'd3, T_SEQ, B_INCR8, 4'b0, 1'b0);
                    cyc();
                    check("t3_wait_hgrant", 32'(bus.hgrant),    32'h2);
                    check("t3_wait_state",  32'(bus.seq_state), 32'd2);
                end
            end
        end

        // Locked SINGLE transfers by master 1 hold off the CPU until the lock drops.
        drive(4'b0010, 2'd1, T_IDLE, B_SINGLE, 4'b0, 1'b1);
        cyc();
        check("t4_owner", 32'(bus.hmaster), 32'd1);
        for (int s = 0; s < 2; s++) begin
            drive(4'b1000, 2'd3, T_NONSEQ, B_SINGLE, 4'b0010, 1'b1);
            cyc();
            check("t4_locked_hgrant", 32'(bus.hgrant),        32'h2);
            check("t4_locked_lock",   32'(bus.hmastlock_out), 32'd1);
        end
        drive(4'b1000, 2'd3, T_NONSEQ, B_SINGLE, 4'b0, 1'b1);
        cyc();
        check("t4_release_hgrant",  32'(bus.hgrant),  32'h8);
        check("t4_release_hmaster", 32'(bus.hmaster), 32'd3);

        // INCR hog by master 2 is forced off after MAX_HOLD cycles.
        drive(4'b0100, 2'd2, T_IDLE, B_SINGLE, 4'b0, 1'b1);
        cyc();
        check("t5_owner", 32'(bus.hmaster), 32'd2);
        drive(4'b0001, 2'd0, T_NONSEQ, B_INCR, 4'b0, 1'b1);
        cyc();
        check("t5_incr_state", 32'(bus.seq_state), 32'd3);
        for (int k = 1; k <= int'(MAX_HOLD); k++) begin
            drive(4'b0001, 2'd0, T_SEQ, B_INCR, 4'b0, 1'b1);
            cyc();
            check($sformatf("t5_force_k%0d", k), 32'(bus.force_release), (k == int'(MAX_HOLD)) ? 32'd1 : 32'd0);
        end
        check("t5_forced_hgrant",  32'(bus.hgrant),  32'h1);
        check("t5_forced_hmaster", 32'(bus.hmaster), 32'd0);
        cyc();
        check("t5_force_pulse_end", 32'(bus.force_release), 32'd0);

        // Same hog with lock held: no forced release.
        drive(4'b0100, 2'd2, T_IDLE, B_SINGLE, 4'b0, 1'b1);
        cyc();
        drive(4'b0001, 2'd0, T_NONSEQ, B_INCR, 4'b0100, 1'b1);
        cyc();
        for (int k = 0; k < 12; k++) begin
            drive(4'b0001, 2'd0, T_SEQ, B_INCR, 4'b0100, 1'b1);
            cyc();
            check("t5_lock_force",  32'(bus.force_release), 32'd0);
            check("t5_lock_hgrant", 32'(bus.hgrant),        32'h4);
        end
        drive(4'b0001, 2'd0, T_IDLE, B_INCR, 4'b0, 1'b1);
        cyc();
        check("t5_unlock_hgrant", 32'(bus.hgrant), 32'h1);

        // Randomized traffic with occasional resets, checked against the model.
        for (int n = 0; n < 3000; n++) begin
            w = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                tr_v[i*2 +: 2] = ($urandom_range(0, 1) == 1) ? T_SEQ : 2'($urandom_range(0, 3));
                hb_v[i*3 +: 3] = 3'($urandom_range(0, 7));
                lk_v[i]        = ($urandom_range(0, 7) == 0);
            end
            bus.arb_winner  = w;
            bus.arb_grant   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'(1 << w);
            bus.m_htrans    = tr_v;
            bus.m_hburst    = hb_v;
            bus.m_hmastlock = lk_v;
            bus.hready      = ($urandom_range(0, 4) != 0);
            rst_n           = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
